// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier dispatcher.
package mult_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 12;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD,
    ERROR
  } state_t;

endpackage

// File: rtl/mult_dispatch_if.sv
// Operand, multiplier and result signals of mult_dispatch; the block uses the slave view.
// acc_sum exists only when MULT_DISPATCH_ACCUM_EN is defined.
interface mult_dispatch_if;
  import mult_pkg::*;

  logic  in_valid;
  logic  in_ready;
  op_t   in_m;
  op_t   in_n;
  logic  mult_start;
  op_t   mult_m;
  op_t   mult_n;
  logic  mult_busy;
  prod_t mult_prod;
  logic  out_valid;
  logic  out_ready;
  prod_t out_prod;
  logic  err;
`ifdef MULT_DISPATCH_ACCUM_EN
  acc_t  acc_sum;
`endif

  modport slave (
    input  in_valid, in_m, in_n, mult_busy, mult_prod, out_ready,
    output in_ready, mult_start, mult_m, mult_n, out_valid, out_prod, err
`ifdef MULT_DISPATCH_ACCUM_EN
    , output acc_sum
`endif
  );

  modport master (
    output in_valid, in_m, in_n, mult_busy, mult_prod, out_ready,
    input  in_ready, mult_start, mult_m, mult_n, out_valid, out_prod, err
`ifdef MULT_DISPATCH_ACCUM_EN
    , input acc_sum
`endif
  );

endinterface

// File: rtl/mult_timeout_ctr.sv
// Saturating cycle counter; expired is high in the LIMIT-th enabled cycle after a clear.
module mult_timeout_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mult_dispatch.sv
// Hands one operand pair at a time to an external shift-add multiplier and holds the product.
// Optional MULT_DISPATCH_ACCUM_EN adds a 12-bit running sum of delivered products (acc_sum).
module mult_dispatch
  import mult_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 4,
  parameter int DONE_TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst,
  mult_dispatch_if.slave bus
);

  state_t state_q, state_d;
  logic   load, capture, state_chg;
  logic   busy_expired, done_expired;
  op_t    m_q, n_q;
  prod_t  prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load           = 1'b0;
    capture        = 1'b0;
    bus.in_ready   = 1'b0;
    bus.mult_start = 1'b0;
    bus.out_valid  = 1'b0;
    bus.err        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.mult_start = 1'b1;
        state_d        = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.mult_busy) begin
          state_d = WAIT_DONE;
        end else if (busy_expired) begin
          state_d = ERROR;
        end
      end
      WAIT_DONE: begin
        // A falling busy in the last allowed cycle still counts as completion.
        if (!bus.mult_busy) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (done_expired) begin
          state_d = ERROR;
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        bus.err = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_chg = (state_d != state_q);

  mult_timeout_ctr #(.LIMIT(BUSY_TIMEOUT)) u_busy_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_chg),
    .enable  (state_q == WAIT_BUSY),
    .expired (busy_expired)
  );

  mult_timeout_ctr #(.LIMIT(DONE_TIMEOUT)) u_done_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_chg),
    .enable  (state_q == WAIT_DONE),
    .expired (done_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= '0;
      n_q    <= '0;
      prod_q <= '0;
    end else begin
      if (load) begin
        m_q <= bus.in_m;
        n_q <= bus.in_n;
      end
      if (capture) begin
        prod_q <= bus.mult_prod;
      end
    end
  end

  assign bus.mult_m   = m_q;
  assign bus.mult_n   = n_q;
  assign bus.out_prod = prod_q;

`ifdef MULT_DISPATCH_ACCUM_EN
  acc_t acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if ((state_q == HOLD) && bus.out_ready) begin
      acc_q <= acc_q + acc_t'(prod_q);
    end
  end

  assign bus.acc_sum = acc_q;
`endif

endmodule

// File: tb/tb_mult_dispatch.sv
// Randomised bench for mult_dispatch: a reference multiplier plus a cycle-arithmetic transaction model.
module tb_mult_dispatch;

  localparam int BT    = 4;
  localparam int DT    = 32;
  localparam int NEVER = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_dispatch_if bus ();

  mult_dispatch #(.BUSY_TIMEOUT(BT), .DONE_TIMEOUT(DT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction model: accept cycle a is the ISSUE cycle; the reference multiplier raises busy in
  // cycle a+d for l cycles, so HOLD starts at a+d+l+1. d=0: busy never rises; l=0: busy never falls.
  bit         active    = 1'b0;
  bit         zero_regs = 1'b1;
  int         t_a, t_h, t_rel, t_err;
  logic [3:0] t_m, t_n;
  int         nd, nl;
  logic [11:0] exp_acc = '0;

  function automatic logic [7:0] pmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] x, y;
    x = {4'b0, a};
    y = {4'b0, b};
    return x * y;
  endfunction

  function automatic bit model_idle(input int c);
    return !active || (c > t_rel);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference shift-add multiplier with driver-chosen timing.
  initial begin : ref_mult
    logic [3:0] lm, ln;
    int dd, ll;
    bus.mult_busy = 1'b0;
    bus.mult_prod = '0;
    forever begin
      @(negedge clk);
      if (bus.mult_start === 1'b1 && !rst) begin
        lm = bus.mult_m;
        ln = bus.mult_n;
        dd = nd;
        ll = nl;
        if (dd != 0) begin
          repeat (dd) @(negedge clk);
          bus.mult_busy = 1'b1;
          bus.mult_prod = 8'($urandom);
          if (ll == 0) begin
            while (!rst) @(negedge clk);
          end else begin
            repeat (ll) @(negedge clk);
          end
          bus.mult_busy = 1'b0;
          bus.mult_prod = pmul(lm, ln);
        end
      end
    end
  end

  // Compare process: every cycle, 2 time units after the rising edge.
  initial begin : compare
    logic e_ir, e_ms, e_ov, e_err;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      e_ir = 1'b1; e_ms = 1'b0; e_ov = 1'b0; e_err = 1'b0;
      if (!rst && active) begin
        if (cyc >= t_err) begin
          e_ir = 1'b0;
          e_err = 1'b1;
        end else if (cyc <= t_rel) begin
          e_ir = 1'b0;
          e_ms = (cyc == t_a);
          e_ov = (cyc >= t_h);
        end
      end
      chk("in_ready", bus.in_ready, e_ir);
      chk("mult_start", bus.mult_start, e_ms);
      chk("out_valid", bus.out_valid, e_ov);
      chk("err", bus.err, e_err);
      if (e_ov) chk("out_prod", bus.out_prod, pmul(t_m, t_n));
      if (active && !rst && cyc >= t_a) chk("mult_operands", {bus.mult_m, bus.mult_n}, {t_m, t_n});
      if (zero_regs) chk("zeroed_regs", {bus.mult_m, bus.mult_n, bus.out_prod}, 16'h0);
`ifdef MULT_DISPATCH_ACCUM_EN
      chk("acc_sum", bus.acc_sum, exp_acc);
`endif
    end
  end

  // Called at a negedge; returns at the negedge of the ISSUE cycle with junk still offered.
  task automatic issue(input logic [3:0] m, input logic [3:0] n, input int d, input int l);
    bus.in_valid = 1'b1;
    bus.in_m = m;
    bus.in_n = n;
    for (int k = 0; k < 200 && !model_idle(cyc); k++) @(negedge clk);
    active = 1'b1; zero_regs = 1'b0;
    t_a = cyc + 1; t_m = m; t_n = n; nd = d; nl = l; t_rel = NEVER;
    if (d == 0) begin
      t_h = NEVER; t_err = t_a + 1 + BT;
    end else if (l == 0) begin
      t_h = NEVER; t_err = t_a + d + 1 + DT;
    end else begin
      t_h = t_a + d + l + 1; t_err = NEVER;
    end
    @(negedge clk);
    bus.in_m = 4'($urandom);
    bus.in_n = 4'($urandom);
  endtask

  task automatic wait_cycle(input int c);
    for (int k = 0; k < 500 && cyc < c; k++) @(negedge clk);
  endtask

  task automatic release_out(input int hold, input bit nv, input logic [3:0] nm, input logic [3:0] nn);
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    t_rel = cyc;
    exp_acc = exp_acc + {4'b0, pmul(t_m, t_n)};
    bus.in_valid = nv;
    bus.in_m = nm;
    bus.in_n = nn;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    active = 1'b0; zero_regs = 1'b1; exp_acc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : driver
    logic [3:0] nm, nn;
    int a0;
    bus.in_valid = 1'b0; bus.in_m = '0; bus.in_n = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(4'd3, 4'd5, 1, 1);     wait_cycle(t_h); chk("prod_3x5", bus.out_prod, 15);
    chk("err_after_3x5", bus.err, 0);
    release_out(0, 1'b0, 4'd0, 4'd0);
    issue(4'd15, 4'd15, BT, 6);  wait_cycle(t_h); chk("prod_15x15", bus.out_prod, 225);
    release_out(10, 1'b1, 4'd0, 4'd9);
    issue(4'd0, 4'd9, 2, DT);    wait_cycle(t_h); chk("prod_0x9", bus.out_prod, 0);
    release_out(1, 1'b0, 4'd0, 4'd0);
    issue(4'd10, 4'd10, 3, 2);   wait_cycle(t_h); chk("prod_10x10", bus.out_prod, 100);
    release_out(0, 1'b0, 4'd0, 4'd0);
`ifdef MULT_DISPATCH_ACCUM_EN
    chk("acc_340", bus.acc_sum, 340);
`endif

    nm = 4'($urandom); nn = 4'($urandom);
    for (int i = 0; i < 40; i++) begin
      logic ov;
      logic [3:0] cm, cn;
      cm = nm; cn = nn;
      nm = 4'($urandom); nn = 4'($urandom);
      ov = (i != 39) && ($urandom_range(0, 1) == 1);
      issue(cm, cn, $urandom_range(1, BT), $urandom_range(1, 12));
      wait_cycle(t_h);
      release_out($urandom_range(0, 3), ov, nm, nn);
    end

    issue(4'd7, 4'd9, 2, 20);
    wait_cycle(t_a + 7);
    do_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_prod", bus.out_prod, 0);
    repeat (30) @(negedge clk);
    issue(4'd7, 4'd9, 2, 3);     wait_cycle(t_h); chk("prod_after_rst", bus.out_prod, 63);
    release_out(0, 1'b0, 4'd0, 4'd0);

    issue(4'd5, 4'd5, 1, 0);
    wait_cycle(t_err + 3);
    chk("done_timeout_err", bus.err, 1);
    do_reset();
    @(negedge clk);

    issue(4'd6, 4'd6, 0, 0);
    a0 = t_a;
    wait_cycle(a0 + BT);
    chk("busy_timeout_early", bus.err, 0);
    @(negedge clk);
    chk("busy_timeout_err", bus.err, 1);
    repeat (10) @(negedge clk);
    chk("error_sticky", bus.err, 1);
    chk("error_in_ready", bus.in_ready, 0);
    do_reset();
    chk("err_cleared", bus.err, 0);

    issue(4'd3, 4'd5, 2, 2);     wait_cycle(t_h); chk("prod_final", bus.out_prod, 15);
    release_out(0, 1'b0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
